// File: rtl/mat_vec_seq.sv
// Sequential 4x4 matrix by 4-vector product in signed fixed point.
// A single multiplier walks the 16 products and the whole result vector is published at once.
//
// state | meaning
// IDLE  | ready for a request
// MAC   | one product per cycle, k = 0..15
// DONE  | result published, valid_out pulse
module mat_vec_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [3:0][3:0][WIDTH-1:0]  mat1_in,
  input  logic [3:0][WIDTH-1:0]       mat2_in,
  output logic                        valid_out,
  output logic [3:0][WIDTH-1:0]       mat_out
);

  localparam int ACCW = 2*WIDTH + 2;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                       state_q, state_d;
  logic                         ready_q, ready_d;
  logic                         valid_q, valid_d;
  logic [3:0][3:0][WIDTH-1:0]   m1_q;
  logic [3:0][WIDTH-1:0]        m2_q;
  logic [3:0][WIDTH-1:0]        res_q;
  logic [3:0][WIDTH-1:0]        out_q;
  logic [3:0]                   k_q;
  logic signed [ACCW-1:0]       acc_q;

  logic                         accept;
  logic [1:0]                   row, col;
  logic signed [2*WIDTH-1:0]    prod;
  logic signed [ACCW-1:0]       acc_base, acc_sum, acc_shr;
  logic [WIDTH-1:0]             sat_val;

  assign accept    = valid_in & ready_q;
  assign row       = k_q[3:2];
  assign col       = k_q[1:0];
  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign mat_out   = out_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (k_q == 4'd15) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_comb begin
    prod     = $signed(m1_q[row][col]) * $signed(m2_q[col]);
    acc_base = (col == 2'd0) ? '0 : acc_q;
    acc_sum  = acc_base + {{2{prod[2*WIDTH-1]}}, prod};
    acc_shr  = acc_sum >>> FRAC;
    if (acc_shr > SAT_MAX) begin
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (acc_shr < SAT_MIN) begin
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat_val = acc_shr[WIDTH-1:0];
    end
  end

  // Row 3 finishes on the same edge the vector is published, so it bypasses res_q.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m1_q  <= '0;
      m2_q  <= '0;
      res_q <= '0;
      out_q <= '0;
      k_q   <= '0;
      acc_q <= '0;
    end else begin
      if (state_q == IDLE && accept) begin
        m1_q  <= mat1_in;
        m2_q  <= mat2_in;
        k_q   <= '0;
        acc_q <= '0;
      end else if (state_q == MAC) begin
        acc_q <= acc_sum;
        k_q   <= k_q + 4'd1;
        if (col == 2'd3) res_q[row] <= sat_val;
        if (k_q == 4'd15) out_q <= {sat_val, res_q[2], res_q[1], res_q[0]};
      end
    end
  end

endmodule

// File: tb/tb_mat_vec_seq.sv
// Directed bench for mat_vec_seq: a cycle-level reference model checked every cycle,
// plus literal expectations for the canonical vectors.
module tb_mat_vec_seq;

  logic                    clk_in;
  logic                    rst_in;
  logic                    valid_in;
  logic                    ready_out;
  logic [3:0][3:0][31:0]   mat1_in;
  logic [3:0][31:0]        mat2_in;
  logic                    valid_out;
  logic [3:0][31:0]        mat_out;

  mat_vec_seq #(.WIDTH(32), .FRAC(16)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .mat1_in  (mat1_in),
    .mat2_in  (mat2_in),
    .valid_out(valid_out),
    .mat_out  (mat_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int vcount = 0;

  always @(posedge clk_in) cyc = cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total = total + 1;
    if (got !== exp) $display("FAIL %s got=%h expected=%h (edge %0d)", name, got, exp, cyc + 1);
    else passed = passed + 1;
  endtask

  function automatic logic [3:0][31:0] model(input logic [3:0][3:0][31:0] a,
                                             input logic [3:0][31:0] b);
    logic [3:0][31:0] r;
    logic signed [71:0] s;
    localparam logic signed [71:0] MX = 72'sd2147483647;
    localparam logic signed [71:0] MN = -72'sd2147483648;
    for (int i = 0; i < 4; i++) begin
      s = '0;
      for (int j = 0; j < 4; j++) s = s + ($signed(a[i][j]) * $signed(b[j]));
      s = s >>> 16;
      if (s > MX) r[i] = 32'h7FFF_FFFF;
      else if (s < MN) r[i] = 32'h8000_0000;
      else r[i] = s[31:0];
    end
    return r;
  endfunction

  // Reference timeline: acceptance at edge T, result visible for edge T+17, ready again at T+18.
  bit               busy = 1'b0;
  bit               block_first = 1'b1;
  int               t_acc = 0;
  logic [3:0][31:0] res_exp = '0;
  logic [3:0][31:0] mat_exp = '0;
  bit               exp_ready, exp_valid;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      busy = 1'b0;
      block_first = 1'b1;
      mat_exp = '0;
      chk("model_ready", ready_out, 1'b0);
      chk("model_valid", valid_out, 1'b0);
      chk("model_mat", mat_out, mat_exp);
    end else begin
      exp_ready = !block_first && !busy;
      exp_valid = busy && ((cyc + 1) == t_acc + 17);
      if (exp_valid) mat_exp = res_exp;
      chk("model_ready", ready_out, exp_ready);
      chk("model_valid", valid_out, exp_valid);
      chk("model_mat", mat_out, mat_exp);
      if (valid_out) vcount = vcount + 1;
      block_first = 1'b0;
      if (exp_valid) busy = 1'b0;
      if (exp_ready && valid_in) begin
        busy = 1'b1;
        t_acc = cyc + 1;
        res_exp = model(mat1_in, mat2_in);
      end
    end
  end

  task automatic send(input bit hold, output int t);
    t = -1000;
    valid_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (ready_out) begin
        t = cyc + 1;
        break;
      end
    end
    if (t < 0) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk_in);
    #1;
    if (!hold) valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int v);
    v = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (valid_out) begin
        v = cyc + 1;
        break;
      end
    end
  endtask

  task automatic set_diag(input logic [31:0] d);
    mat1_in = '0;
    for (int i = 0; i < 4; i++) mat1_in[i][i] = d;
  endtask

  int t, v, v2, vbefore;

  initial begin
    rst_in = 1'b1;
    valid_in = 1'b0;
    mat1_in = '0;
    mat2_in = '0;
    #1 rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_ready", ready_out, 1'b0);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_mat", mat_out, 128'h0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("ready_after_release", ready_out, 1'b1);

    // identity
    set_diag(32'h0001_0000);
    mat2_in = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    send(1'b0, t);
    wait_valid(v);
    chk("id_latency", 128'(v - t), 128'd17);
    chk("id_result", mat_out, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000});
    @(posedge clk_in);
    #1;

    // sign and fraction: -1.0*2.0 + 0.5*2.0 = -1.0
    mat1_in = '0;
    mat1_in[0][0] = 32'hFFFF_0000;
    mat1_in[0][1] = 32'h0000_8000;
    mat2_in = {32'h0, 32'h0, 32'h0002_0000, 32'h0002_0000};
    send(1'b0, t);
    wait_valid(v);
    chk("sign_latency", 128'(v - t), 128'd17);
    chk("sign_row0", mat_out[0], 32'hFFFF_0000);
    chk("sign_all", mat_out, {32'h0, 32'h0, 32'h0, 32'hFFFF_0000});
    @(posedge clk_in);
    #1;

    // positive saturation
    mat1_in = {16{32'h7FFF_FFFF}};
    mat2_in = {4{32'h7FFF_FFFF}};
    send(1'b0, t);
    wait_valid(v);
    chk("sat_pos", mat_out, {4{32'h7FFF_FFFF}});
    @(posedge clk_in);
    #1;

    // negative saturation
    mat1_in = {16{32'h8000_0000}};
    mat2_in = {4{32'h7FFF_FFFF}};
    send(1'b0, t);
    wait_valid(v);
    chk("sat_neg", mat_out, {4{32'h8000_0000}});
    @(posedge clk_in);
    #1;

    // back-to-back with operands changed right after acceptance
    set_diag(32'h0001_0000);
    mat2_in = {32'h0008_0000, 32'h0007_0000, 32'h0006_0000, 32'h0005_0000};
    send(1'b1, t);
    set_diag(32'h0002_0000);
    mat2_in = {32'h0003_0000, 32'h0000_4000, 32'hFFFF_0000, 32'h0001_0000};
    wait_valid(v);
    chk("b2b_first_latency", 128'(v - t), 128'd17);
    chk("b2b_first_result", mat_out, {32'h0008_0000, 32'h0007_0000, 32'h0006_0000, 32'h0005_0000});
    wait_valid(v2);
    valid_in = 1'b0;
    chk("b2b_second_latency", 128'(v2 - t), 128'd35);
    chk("b2b_second_result", mat_out, {32'h0006_0000, 32'h0000_8000, 32'hFFFE_0000, 32'h0002_0000});
    @(posedge clk_in);
    #1;

    // reset in the middle of an operation
    set_diag(32'h0001_0000);
    mat2_in = {32'h0009_0000, 32'h0009_0000, 32'h0009_0000, 32'h0009_0000};
    vbefore = vcount;
    send(1'b0, t);
    repeat (7) @(posedge clk_in);
    #1 rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    chk("midrst_ready_held", ready_out, 1'b0);
    @(posedge clk_in);
    #1;
    chk("midrst_ready_release", ready_out, 1'b1);
    repeat (25) @(posedge clk_in);
    #1;
    chk("midrst_no_valid", 128'(vcount - vbefore), 128'd0);
    chk("midrst_mat_zero", mat_out, 128'h0);

    // fresh identity request after the abandoned one
    mat2_in = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    send(1'b0, t);
    wait_valid(v);
    chk("post_rst_latency", 128'(v - t), 128'd17);
    chk("post_rst_result", mat_out, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000});
    repeat (3) @(posedge clk_in);
    #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
